fetch_issue_unit: RTL



---
 rtl/fetch_issue_unit_pkg.sv | 28 ++
 rtl/fetch_issue_unit_next_pc_calc.sv | 31 +++
 rtl/fetch_issue_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_issue_unit_pkg.sv
// Shared definitions for the fetch/issue unit and the control decoder.
package fetch_issue_unit_pkg;

  // Opcodes the control decoder understands.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Fetch FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // Sequential PC increment in bytes.
  localparam int unsigned PC_STEP = 4;

  // Width of the fetch timeout counter.
  localparam int unsigned CNT_W = 4;

  // True when the opcode belongs to the supported instruction subset.
  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_STORE) ||
           (op == OP_LOAD)  || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_issue_unit_next_pc_calc.sv
// Next-PC calculation: B-immediate extraction, target adder, misalignment check.
module fetch_issue_unit_next_pc_calc
  import fetch_issue_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic              take,
  output logic [ADDR_W-1:0] next_pc_c,
  output logic              misaligned_c
);

  logic [12:0]       imm_b;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] target;
  logic              unused_instr_bits;

  // B-type immediate, sign-extended to the address width; adds wrap modulo 2^ADDR_W.
  always_comb begin
    imm_b        = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_ext      = {{(ADDR_W-13){imm_b[12]}}, imm_b};
    target       = pc + imm_ext;
    next_pc_c    = take ? target : (pc + ADDR_W'(PC_STEP));
    misaligned_c = take && target[1];
  end

  // Opcode/register fields do not contribute to the immediate.
  assign unused_instr_bits = ^{instr[24:12], instr[6:0]};

endmodule

// File: rtl/fetch_issue_unit.sv
// Fetch/issue unit: fetches instructions over a req/ack port, presents them
// under valid/ready, and steps the PC (sequential or taken branch).
// Optional build macro FETCH_ILLEGAL_OP_EN adds the illegal_op output and
// faults on acceptance of an unsupported opcode.
module fetch_issue_unit
  import fetch_issue_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [31:0]       instr,
  output logic [6:0]        opcode,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
`ifdef FETCH_ILLEGAL_OP_EN
  output logic              illegal_op,
`endif
  output logic              fault
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              fault_q, fault_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              illegal_op_q, illegal_op_d;

  logic              take_c;
  logic [ADDR_W-1:0] next_pc_c;
  logic              misaligned_c;

  assign take_c = branch && zero;

  fetch_issue_unit_next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc_calc (
    .pc           (pc_q),
    .instr        (instr_q),
    .take         (take_c),
    .next_pc_c    (next_pc_c),
    .misaligned_c (misaligned_c)
  );

  // Next-state logic; outputs are registered from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          wait_cnt_d = '0;
          state_d    = ST_ISSUE;
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      ST_ISSUE: begin
        if (instr_ready) begin
          if (misaligned_c || illegal_op_q) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            pc_d    = next_pc_c;
            state_d = ST_REQ;
          end
        end
      end

      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_IDLE;
    endcase

    imem_req_d    = (state_d == ST_REQ);
    imem_addr_d   = imem_req_d ? pc_d : '0;
    instr_valid_d = (state_d == ST_ISSUE);
    opcode_d      = instr_d[6:0];
`ifdef FETCH_ILLEGAL_OP_EN
    illegal_op_d  = instr_valid_d && !is_legal_op(instr_d[6:0]);
`else
    illegal_op_d  = 1'b0;
`endif
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      opcode_q      <= '0;
      wait_cnt_q    <= '0;
      fault_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_valid_q <= 1'b0;
      illegal_op_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      opcode_q      <= opcode_d;
      wait_cnt_q    <= wait_cnt_d;
      fault_q       <= fault_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      illegal_op_q  <= illegal_op_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign opcode      = opcode_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign fault       = fault_q;
`ifdef FETCH_ILLEGAL_OP_EN
  assign illegal_op  = illegal_op_q;
`endif

endmodule
